// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation and
// FSM-state encodings, the request bundle, and small helpers for operation
// signedness and 32-bit word extension.
package muldiv_unit_pkg;

    localparam int unsigned MAX_XLEN = 64;

    typedef enum logic [2:0] {
        MUL    = 3'd0,
        MULH   = 3'd1,
        MULHSU = 3'd2,
        MULHU  = 3'd3,
        DIV    = 3'd4,
        DIVU   = 3'd5,
        REM    = 3'd6,
        REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } muldiv_state_e;

    // Operands are carried at the widest legal width; narrower units use the low bits.
    typedef struct packed {
        muldiv_op_e            op;
        logic                  word;
        logic [MAX_XLEN-1:0]   rs1;
        logic [MAX_XLEN-1:0]   rs2;
    } muldiv_req_t;

    function automatic logic op_is_div(input muldiv_op_e op);
        return op[2];
    endfunction

    // rs1 is treated as signed by MULH, MULHSU, DIV and REM.
    function automatic logic op_a_signed(input muldiv_op_e op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    // rs2 is treated as signed by MULH, DIV and REM.
    function automatic logic op_b_signed(input muldiv_op_e op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic [63:0] sext_w(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    function automatic logic [63:0] zext_w(input logic [63:0] v);
        return {32'h0000_0000, v[31:0]};
    endfunction

endpackage

// File: rtl/muldiv_unit_operand_prep.sv
// Combinational operand preparation for muldiv_unit.
//   req            : incoming request (op, word flag, rs1, rs2)
//   word_eff       : word flag qualified by XLEN (only meaningful at 64 bits)
//   abs_a, abs_b   : operand magnitudes fed to the iterative datapath
//   neg_res        : product / quotient must be negated at the end
//   neg_rem        : remainder must be negated (follows the dividend sign)
//   special        : divide-by-zero or signed overflow, answered without iterating
//   special_result : the result for those special cases
module muldiv_operand_prep
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  muldiv_req_t       req,
    output logic              word_eff,
    output logic [XLEN-1:0]   abs_a,
    output logic [XLEN-1:0]   abs_b,
    output logic              neg_res,
    output logic              neg_rem,
    output logic              special,
    output logic [XLEN-1:0]   special_result
);

    localparam logic [XLEN-1:0] ONE_X  = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ZERO_X = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] ONES_X = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] MIN_X  = {1'b1, {(XLEN-1){1'b0}}};

    logic [63:0]     ext_a64_s;
    logic [63:0]     ext_b64_s;
    logic [63:0]     dvd64_s;
    logic [63:0]     min64_s;
    logic [XLEN-1:0] ext_a_s;
    logic [XLEN-1:0] ext_b_s;
    logic [XLEN-1:0] dvd_s;
    logic [XLEN-1:0] min_s;
    logic            sign_a_s;
    logic            sign_b_s;
    logic            div_zero_s;
    logic            ovf_s;

    // Extend operands, take magnitudes and classify special divide cases.
    always_comb begin
        word_eff = (XLEN == 64) && req.word;
        min64_s  = sext_w(64'h0000_0000_8000_0000);
        if (word_eff) begin
            ext_a64_s = op_a_signed(req.op) ? sext_w(req.rs1) : zext_w(req.rs1);
            ext_b64_s = op_b_signed(req.op) ? sext_w(req.rs2) : zext_w(req.rs2);
            // Divide-by-zero remainder is the sign-extended low word for both REMW and REMUW.
            dvd64_s   = sext_w(req.rs1);
            min_s     = min64_s[XLEN-1:0];
        end else begin
            ext_a64_s = req.rs1;
            ext_b64_s = req.rs2;
            dvd64_s   = req.rs1;
            min_s     = MIN_X;
        end
        ext_a_s  = ext_a64_s[XLEN-1:0];
        ext_b_s  = ext_b64_s[XLEN-1:0];
        dvd_s    = dvd64_s[XLEN-1:0];

        sign_a_s = op_a_signed(req.op) && ext_a_s[XLEN-1];
        sign_b_s = op_b_signed(req.op) && ext_b_s[XLEN-1];
        abs_a    = sign_a_s ? (~ext_a_s + ONE_X) : ext_a_s;
        abs_b    = sign_b_s ? (~ext_b_s + ONE_X) : ext_b_s;
        neg_res  = sign_a_s ^ sign_b_s;
        neg_rem  = sign_a_s;

        div_zero_s = op_is_div(req.op) && (ext_b_s == ZERO_X);
        ovf_s      = ((req.op == DIV) || (req.op == REM)) &&
                     (ext_a_s == min_s) && (ext_b_s == ONES_X);
        special    = div_zero_s || ovf_s;

        case (req.op)
            DIV, DIVU: special_result = div_zero_s ? ONES_X : dvd_s;
            REM, REMU: special_result = div_zero_s ? dvd_s : ZERO_X;
            default:   special_result = ZERO_X;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative radix-2 RV64M multiply/divide unit with valid/ready on both sides.
//   clk, rst_n (sync, active-low), flush (abort in-flight op)
//   in_valid/in_ready, in_op, in_word, in_rs1, in_rs2 : request side
//   out_valid/out_ready, out_result                     : result side
// One operation in flight; MSB-first shift-add multiply and restoring divide,
// then a single fix-up cycle applying signs and selecting the result half.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic              in_word,
    input  logic [XLEN-1:0]   in_rs1,
    input  logic [XLEN-1:0]   in_rs2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result
);

    localparam int unsigned     CW       = $clog2(XLEN);
    localparam logic [CW-1:0]   CNT_FULL = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_WORD = CW'(31);
    localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ONE_X    = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ZERO_X   = {XLEN{1'b0}};
    localparam logic [2*XLEN-1:0] ONE_2X  = {{(2*XLEN-1){1'b0}}, 1'b1};
    localparam logic [2*XLEN-1:0] ZERO_2X = {(2*XLEN){1'b0}};

    muldiv_state_e     state_q, state_d;
    muldiv_op_e        op_q, op_d;
    logic              word_q, word_d;
    logic              neg_res_q, neg_res_d;
    logic              neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]   a_q, a_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    // Multiply: full product. Divide: {remainder, quotient}.
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   result_q, result_d;

    muldiv_req_t       req_s;
    logic              word_eff_s;
    logic [XLEN-1:0]   abs_a_s, abs_b_s, special_res_s;
    logic              neg_res_s, neg_rem_s, special_s;
    logic [XLEN:0]     rem_shift_s;
    logic [XLEN-1:0]   rem_next_s;
    logic              qbit_s;
    logic [2*XLEN-1:0] calc_acc_s;
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s;
    logic [XLEN-1:0]   sel_s;
    logic [63:0]       sel64_s;
    logic [XLEN-1:0]   fix_result_s;

    // Bundle the raw request for the operand-preparation stage.
    always_comb begin
        req_s      = '0;
        req_s.op   = muldiv_op_e'(in_op);
        req_s.word = in_word;
        req_s.rs1  = 64'(in_rs1);
        req_s.rs2  = 64'(in_rs2);
    end

    muldiv_operand_prep #(.XLEN(XLEN)) u_prep (
        .req            (req_s),
        .word_eff       (word_eff_s),
        .abs_a          (abs_a_s),
        .abs_b          (abs_b_s),
        .neg_res        (neg_res_s),
        .neg_rem        (neg_rem_s),
        .special        (special_s),
        .special_result (special_res_s)
    );

    // One radix-2 step, consuming operand bit cnt_q (MSB first).
    always_comb begin
        rem_shift_s = {acc_q[2*XLEN-1:XLEN], a_q[cnt_q]};
        rem_next_s  = rem_shift_s[XLEN-1:0];
        qbit_s      = 1'b0;
        calc_acc_s  = acc_q;
        if (op_is_div(op_q)) begin
            if (rem_shift_s >= {1'b0, b_q}) begin
                rem_next_s = rem_shift_s[XLEN-1:0] - b_q;
                qbit_s     = 1'b1;
            end else begin
                rem_next_s = rem_shift_s[XLEN-1:0];
                qbit_s     = 1'b0;
            end
            calc_acc_s = {rem_next_s, acc_q[XLEN-2:0], qbit_s};
        end else begin
            calc_acc_s = {acc_q[2*XLEN-2:0], 1'b0} +
                         (b_q[cnt_q] ? {ZERO_X, a_q} : ZERO_2X);
        end
    end

    // Apply result signs, pick the requested half and word-extend if needed.
    always_comb begin
        prod_s = neg_res_q ? (~acc_q + ONE_2X) : acc_q;
        quo_s  = neg_res_q ? (~acc_q[XLEN-1:0] + ONE_X) : acc_q[XLEN-1:0];
        rem_s  = neg_rem_q ? (~acc_q[2*XLEN-1:XLEN] + ONE_X) : acc_q[2*XLEN-1:XLEN];
        case (op_q)
            MUL:                 sel_s = prod_s[XLEN-1:0];
            MULH, MULHSU, MULHU: sel_s = prod_s[2*XLEN-1:XLEN];
            DIV, DIVU:           sel_s = quo_s;
            REM, REMU:           sel_s = rem_s;
            default:             sel_s = ZERO_X;
        endcase
        sel64_s = sext_w(64'(sel_s));
        if (word_q) begin
            fix_result_s = sel64_s[XLEN-1:0];
        end else begin
            fix_result_s = sel_s;
        end
    end

    // FSM next-state and register updates; flush overrides everything but reset.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        word_d    = word_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        result_d  = result_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_d      = req_s.op;
                        word_d    = word_eff_s;
                        neg_res_d = neg_res_s;
                        neg_rem_d = neg_rem_s;
                        a_d       = abs_a_s;
                        b_d       = abs_b_s;
                        acc_d     = ZERO_2X;
                        cnt_d     = word_eff_s ? CNT_WORD : CNT_FULL;
                        if (special_s) begin
                            result_d = special_res_s;
                            state_d  = DONE;
                        end else begin
                            state_d  = CALC;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    acc_d = calc_acc_s;
                    if (cnt_q == CNT_ZERO) begin
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                FIX: begin
                    result_d = fix_result_s;
                    state_d  = DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= MUL;
            word_q    <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= ZERO_X;
            b_q       <= ZERO_X;
            cnt_q     <= CNT_ZERO;
            acc_q     <= ZERO_2X;
            result_q  <= ZERO_X;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            word_q    <= word_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            a_q       <= a_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign out_valid  = (state_q == DONE);
    assign out_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=64): directed spec cases, flush
// and reset behaviour, then randomized operations against an arithmetic model.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = 3'd0;
    logic        in_word = 1'b0;
    logic [63:0] in_rs1 = 64'd0;
    logic [63:0] in_rs2 = 64'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_result;

    int nvec = 0;
    int nerr = 0;

    muldiv_unit #(.XLEN(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_word    (in_word),
        .in_rs1     (in_rs1),
        .in_rs2     (in_rs2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: RISC-V M-extension semantics with plain arithmetic.
    function automatic void model(input logic [2:0] op, input logic w,
                                  input logic [63:0] a, input logic [63:0] b,
                                  output logic [63:0] res, output int lat);
        logic signed [127:0] xa, xb, p;
        logic [127:0]        pu;
        longint              sa, sb;
        int                  a32, b32, r32;
        int unsigned         ua32, ub32;
        lat = w ? 34 : 66;
        res = 64'd0;
        if (!w) begin
            sa = a; sb = b;
            case (op)
                3'd0: res = a * b;
                3'd1: begin xa = sa; xb = sb; p = xa * xb; res = p[127:64]; end
                3'd2: begin xa = sa; xb = {64'd0, b}; p = xa * xb; res = p[127:64]; end
                3'd3: begin pu = {64'd0, a} * {64'd0, b}; res = pu[127:64]; end
                3'd4: if (b == 64'd0) begin res = '1; lat = 1; end
                      else if (a == 64'h8000_0000_0000_0000 && b == '1) begin res = a; lat = 1; end
                      else res = 64'(sa / sb);
                3'd5: if (b == 64'd0) begin res = '1; lat = 1; end else res = a / b;
                3'd6: if (b == 64'd0) begin res = a; lat = 1; end
                      else if (a == 64'h8000_0000_0000_0000 && b == '1) begin res = 64'd0; lat = 1; end
                      else res = 64'(sa % sb);
                default: if (b == 64'd0) begin res = a; lat = 1; end else res = a % b;
            endcase
        end else begin
            a32 = a[31:0]; b32 = b[31:0]; ua32 = a[31:0]; ub32 = b[31:0];
            case (op)
                3'd0: r32 = a32 * b32;
                3'd4: if (b32 == 0) begin r32 = -1; lat = 1; end
                      else if (a32 == 32'h8000_0000 && b32 == -1) begin r32 = a32; lat = 1; end
                      else r32 = a32 / b32;
                3'd5: if (ub32 == 0) begin r32 = -1; lat = 1; end else r32 = int'(ua32 / ub32);
                3'd6: if (b32 == 0) begin r32 = a32; lat = 1; end
                      else if (a32 == 32'h8000_0000 && b32 == -1) begin r32 = 0; lat = 1; end
                      else r32 = a32 % b32;
                default: if (ub32 == 0) begin r32 = a32; lat = 1; end else r32 = int'(ua32 % ub32);
            endcase
            res = {{32{r32[31]}}, r32};
        end
    endfunction

    task automatic run_op(input string tag, input logic [2:0] op, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input int hold, output logic [63:0] got);
        logic [63:0] exp;
        int          elat, lat;
        bit          busy_bad, hold_bad;
        model(op, w, a, b, exp, elat);
        @(negedge clk);
        chk({tag, ":rdy"}, 64'(in_ready), 64'd1);
        in_valid = 1'b1; in_op = op; in_word = w; in_rs1 = a; in_rs2 = b;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0; busy_bad = 1'b0;
        do begin
            @(negedge clk);
            lat++;
            if (in_ready) busy_bad = 1'b1;
        end while (!out_valid && lat < 200);
        chk({tag, ":lat"}, 64'(lat), 64'(elat));
        chk({tag, ":busy"}, 64'(busy_bad), 64'd0);
        got = out_result;
        chk({tag, ":res"}, got, exp);
        hold_bad = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            if (out_result !== got || out_valid !== 1'b1 || in_ready !== 1'b0) hold_bad = 1'b1;
        end
        if (hold > 0) chk({tag, ":hold"}, 64'(hold_bad), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, ":after"}, {62'd0, in_ready, out_valid}, 64'd2);
    endtask

    initial begin
        logic [63:0] got, ra, rb;
        logic [2:0]  op;
        logic        w;
        int          sel;
        bit          seen;

        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst:in_ready", 64'(in_ready), 64'd1);
        chk("rst:out_valid", 64'(out_valid), 64'd0);
        chk("rst:out_result", out_result, 64'd0);

        // Directed cases
        run_op("mul7x-3", MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0, got);
        chk("mul7x-3:k", got, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mulhu", MULHU, 1'b0, '1, '1, 0, got);
        chk("mulhu:k", got, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulhsu", MULHSU, 1'b0, '1, 64'd2, 0, got);
        chk("mulhsu:k", got, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("div5/0", DIV, 1'b0, 64'd5, 64'd0, 0, got);
        chk("div5/0:k", got, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("rem5/0", REM, 1'b0, 64'd5, 64'd0, 0, got);
        chk("rem5/0:k", got, 64'd5);
        run_op("divovf", DIV, 1'b0, 64'h8000_0000_0000_0000, '1, 0, got);
        chk("divovf:k", got, 64'h8000_0000_0000_0000);
        run_op("removf", REM, 1'b0, 64'h8000_0000_0000_0000, '1, 0, got);
        chk("removf:k", got, 64'd0);
        run_op("divw", DIV, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 0, got);
        chk("divw:k", got, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("remw", REM, 1'b1, 64'h0000_0001_FFFF_FFF9, 64'd2, 0, got);
        chk("remw:k", got, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("backpr", MULH, 1'b0, 64'hDEAD_BEEF_0123_4567, 64'hF00D_CAFE_89AB_CDEF, 10, got);

        // Flush during a DIVU, with a simultaneous (special-case) request
        @(negedge clk);
        in_valid = 1'b1; in_op = DIVU; in_word = 1'b0;
        in_rs1 = 64'h1234_5678_9ABC_DEF0; in_rs2 = 64'd3;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (20) @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; in_op = DIV; in_rs1 = 64'd5; in_rs2 = 64'd0;
        @(posedge clk);
        #1 flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush:in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("flush:no_out", 64'(seen), 64'd0);

        // Reset in the middle of a multiply (previous result is non-zero)
        @(negedge clk);
        in_valid = 1'b1; in_op = MUL; in_word = 1'b0; in_rs1 = 64'd3; in_rs2 = 64'd5;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("midrst:out_valid", 64'(out_valid), 64'd0);
        chk("midrst:out_result", out_result, 64'd0);
        chk("midrst:in_ready", 64'(in_ready), 64'd1);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("midrst:no_out", 64'(seen), 64'd0);

        // Randomized operations
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom_range(0, 7));
            w   = (op == 3'd0 || op[2]) ? 1'($urandom_range(0, 1)) : 1'b0;
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            sel = $urandom_range(0, 7);
            case (sel)
                0: rb = w ? {$urandom, 32'd0} : 64'd0;
                1: begin
                    ra = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
                    rb = w ? {$urandom, 32'hFFFF_FFFF} : '1;
                end
                2: rb = {$urandom, 16'd0, 16'($urandom)};
                default: ;
            endcase
            run_op($sformatf("rnd%0d", i), op, w, ra, rb, $urandom_range(0, 3), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
